img_src_frame_arbiter: RTL and testbench

// - Frame-level arbiter between two camera pixel streams. It feeds the single img_data_pkt

---
 rtl/img_src_frame_arbiter.sv | 161 ++++++++++++++++
 tb/tb_img_src_frame_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_src_frame_arbiter.sv
// Frame-level arbiter: picks one of two cam_pclk-synchronous pixel streams per frame and checks geometry.
// Latency: 2 cam_pclk cycles from source pins to img_* outputs (two input stages, outputs registered).
// Backpressure: none; the packetizer must accept every img_data_en cycle, and frames are never split.
module img_src_frame_arbiter #(
  parameter logic [15:0] H_PIXEL     = 16'd1280,
  parameter logic [15:0] V_PIXEL     = 16'd720,
  parameter logic [23:0] TIMEOUT_CYC = 24'd8000000
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        transfer_flag,
  input  logic [1:0]  cfg_mode,
  input  logic        src0_vsync,
  input  logic        src0_de,
  input  logic [15:0] src0_data,
  input  logic        src1_vsync,
  input  logic        src1_de,
  input  logic [15:0] src1_data,
  output logic        img_vsync,
  output logic        img_data_en,
  output logic [15:0] img_data,
  output logic        cur_src,
  output logic [15:0] frame_cnt,
  output logic        frame_err,
  output logic        src_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, EOF_ST} state_t;

  state_t      state;
  logic        s0_vsync_d0, s0_vsync_d1, s1_vsync_d0, s1_vsync_d1;
  logic        s0_de_d0, s0_de_d1, s1_de_d0, s1_de_d1;
  logic [15:0] s0_data_d0, s0_data_d1, s1_data_d0, s1_data_d1;
  logic [15:0] pix_cnt;
  logic [15:0] line_cnt;
  logic [23:0] tmo_cnt;
  logic        line_err;
  logic        alt_mode;

  logic        sel_vsync_d0, sel_vsync_d1, sel_de_d0, sel_de_d1;
  logic [15:0] sel_data_d0;
  logic        sof, eof, line_end, tmo_hit, fixed_src, active_nxt;

  assign sel_vsync_d0 = cur_src ? s1_vsync_d0 : s0_vsync_d0;
  assign sel_vsync_d1 = cur_src ? s1_vsync_d1 : s0_vsync_d1;
  assign sel_de_d0    = cur_src ? s1_de_d0    : s0_de_d0;
  assign sel_de_d1    = cur_src ? s1_de_d1    : s0_de_d1;
  assign sel_data_d0  = cur_src ? s1_data_d0  : s0_data_d0;

  assign sof       = sel_vsync_d1 & ~sel_vsync_d0;
  assign eof       = ~sel_vsync_d1 & sel_vsync_d0;
  assign line_end  = sel_de_d1 & ~sel_de_d0;
  assign tmo_hit   = (tmo_cnt == TIMEOUT_CYC - 24'd1);
  assign fixed_src = cfg_mode[0] & ~cfg_mode[1];

  // Outputs are registered from the next state and the d0 stage, so at every cycle they show
  // exactly the d1 sample gated by the current state, without adding a third cycle of latency.
  assign active_nxt = transfer_flag &
                      (((state == WAIT_SOF) & sof) | ((state == ACTIVE) & ~eof));

  // Two-stage input pipeline for both sources; vsync resets high (blanking) so no false edge at start.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vsync_d0 <= 1'b1;  s0_vsync_d1 <= 1'b1;
      s1_vsync_d0 <= 1'b1;  s1_vsync_d1 <= 1'b1;
      s0_de_d0    <= 1'b0;  s0_de_d1    <= 1'b0;
      s1_de_d0    <= 1'b0;  s1_de_d1    <= 1'b0;
      s0_data_d0  <= '0;    s0_data_d1  <= '0;
      s1_data_d0  <= '0;    s1_data_d1  <= '0;
    end else begin
      s0_vsync_d0 <= src0_vsync;  s0_vsync_d1 <= s0_vsync_d0;
      s1_vsync_d0 <= src1_vsync;  s1_vsync_d1 <= s1_vsync_d0;
      s0_de_d0    <= src0_de;     s0_de_d1    <= s0_de_d0;
      s1_de_d0    <= src1_de;     s1_de_d1    <= s1_de_d0;
      s0_data_d0  <= src0_data;   s0_data_d1  <= s0_data_d0;
      s1_data_d0  <= src1_data;   s1_data_d1  <= s1_data_d0;
    end
  end

  // Frame FSM with geometry counters, source selection and registered outputs.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      img_vsync   <= 1'b1;
      img_data_en <= 1'b0;
      img_data    <= '0;
      cur_src     <= 1'b0;
      frame_cnt   <= '0;
      frame_err   <= 1'b0;
      src_timeout <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      tmo_cnt     <= '0;
      line_err    <= 1'b0;
      alt_mode    <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      src_timeout <= 1'b0;
      img_vsync   <= active_nxt ? sel_vsync_d0 : 1'b1;
      img_data_en <= active_nxt & sel_de_d0;
      img_data    <= (active_nxt & sel_de_d0) ? sel_data_d0 : 16'h0000;
      if (!transfer_flag) begin
        // Disable beats any frame event in the same cycle.
        state    <= IDLE;
        pix_cnt  <= '0;
        line_cnt <= '0;
        tmo_cnt  <= '0;
        line_err <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            alt_mode <= (cfg_mode == 2'b10);
            if (cfg_mode != 2'b10) cur_src <= fixed_src;
            state <= WAIT_SOF;
          end
          WAIT_SOF: begin
            if (sof) begin
              // SOF wins over a timeout landing in the same cycle.
              state    <= ACTIVE;
              pix_cnt  <= '0;
              line_cnt <= '0;
              tmo_cnt  <= '0;
            end else if (tmo_hit) begin
              // Fixed modes just park at the limit; alternate mode skips the silent source.
              if (alt_mode) begin
                cur_src     <= ~cur_src;
                src_timeout <= 1'b1;
                tmo_cnt     <= '0;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 24'd1;
            end
          end
          ACTIVE: begin
            if (sel_de_d1) begin
              if (line_end) begin
                if (pix_cnt + 16'd1 != H_PIXEL) line_err <= 1'b1;
                line_cnt <= (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
                pix_cnt  <= '0;
              end else begin
                pix_cnt <= (pix_cnt == 16'hFFFF) ? pix_cnt : pix_cnt + 16'd1;
              end
            end
            if (eof) state <= EOF_ST;
          end
          EOF_ST: begin
            frame_err <= line_err | (line_cnt != V_PIXEL);
            frame_cnt <= frame_cnt + 16'd1;
            alt_mode  <= (cfg_mode == 2'b10);
            cur_src   <= (cfg_mode == 2'b10) ? ~cur_src : fixed_src;
            line_err  <= 1'b0;
            tmo_cnt   <= '0;
            state     <= WAIT_SOF;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_src_frame_arbiter.sv
// Directed bench for img_src_frame_arbiter with a 4x3 frame geometry and a 100-cycle SOF timeout.
// Output frames are captured on the falling clock edge and compared to hand-derived values.
// Pixel data encodes {source, line, pixel} so mixed-source frames are detectable.
module tb_img_src_frame_arbiter;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        transfer_flag = 1'b0;
  logic [1:0]  cfg_mode = 2'b00;
  logic        src0_vsync = 1'b1, src0_de = 1'b0;
  logic [15:0] src0_data = '0;
  logic        src1_vsync = 1'b1, src1_de = 1'b0;
  logic [15:0] src1_data = '0;
  logic        img_vsync, img_data_en, cur_src, frame_err, src_timeout;
  logic [15:0] img_data, frame_cnt;

  img_src_frame_arbiter #(.H_PIXEL(16'd4), .V_PIXEL(16'd3), .TIMEOUT_CYC(24'd100)) dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .transfer_flag(transfer_flag), .cfg_mode(cfg_mode),
    .src0_vsync(src0_vsync), .src0_de(src0_de), .src0_data(src0_data),
    .src1_vsync(src1_vsync), .src1_de(src1_de), .src1_data(src1_data),
    .img_vsync(img_vsync), .img_data_en(img_data_en), .img_data(img_data),
    .cur_src(cur_src), .frame_cnt(frame_cnt), .frame_err(frame_err), .src_timeout(src_timeout)
  );

  always #5 cam_pclk = ~cam_pclk;

  int cyc = 0;
  always @(posedge cam_pclk) cyc++;

  int vec_cnt = 0;
  int miscmp  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor state.
  int fr_src[32], fr_pix[32], fr_mix[32], fr_sum[32];
  int nfr = 0, nfall = 0, en_total = 0;
  int cur_pix = 0, cur_tag = -1, cur_mix = 0, cur_sum = 0;
  int img_fall_cyc = 0, rise_cyc = 0, to_cyc = 0;
  int err_pulses = 0, err_hi = 0, to_pulses = 0, to_hi = 0;
  int drv_fall_cyc[2];
  logic prev_vs = 1'b1, prev_err = 1'b0, prev_to = 1'b0;

  // Capture output frames, pulse counts and event timestamps on the falling edge.
  always @(negedge cam_pclk) begin
    if (rst_n) begin
      if (prev_vs && !img_vsync) begin
        nfall++; cur_pix = 0; cur_tag = -1; cur_mix = 0; cur_sum = 0; img_fall_cyc = cyc;
      end
      if (img_data_en) begin
        en_total++; cur_pix++; cur_sum += int'(img_data);
        if (cur_tag < 0) cur_tag = int'(img_data[15:12]);
        else if (cur_tag != int'(img_data[15:12])) cur_mix = 1;
      end
      if (!prev_vs && img_vsync) begin
        if (nfr < 32) begin
          fr_src[nfr] = cur_tag; fr_pix[nfr] = cur_pix; fr_mix[nfr] = cur_mix; fr_sum[nfr] = cur_sum;
        end
        nfr++; rise_cyc = cyc;
      end
      if (frame_err) err_hi++;
      if (frame_err && !prev_err) err_pulses++;
      if (src_timeout) to_hi++;
      if (src_timeout && !prev_to) begin to_pulses++; to_cyc = cyc; end
    end
    prev_vs = img_vsync; prev_err = frame_err; prev_to = src_timeout;
  end

  task automatic set_vs(input int s, input logic v);
    if (s == 0) src0_vsync = v; else src1_vsync = v;
  endtask

  task automatic set_px(input int s, input logic de, input logic [15:0] d);
    if (s == 0) begin src0_de = de; src0_data = d; end
    else        begin src1_de = de; src1_data = d; end
  endtask

  // One source frame: 'lines' lines of 'ppl' pixels, the last line carries 'last_ppl' pixels.
  task automatic send_frame(input int s, input int lines, input int ppl, input int last_ppl);
    logic [15:0] d;
    @(negedge cam_pclk);
    set_vs(s, 1'b0);
    drv_fall_cyc[s] = cyc;
    repeat (3) @(negedge cam_pclk);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ((l == lines - 1) ? last_ppl : ppl); p++) begin
        d = {s[3:0], l[3:0], p[7:0]};
        set_px(s, 1'b1, d);
        @(negedge cam_pclk);
      end
      set_px(s, 1'b0, 16'h0000);
      repeat (3) @(negedge cam_pclk);
    end
    repeat (2) @(negedge cam_pclk);
    set_vs(s, 1'b1);
    repeat (6) @(negedge cam_pclk);
  endtask

  function automatic int exp_sum(input int s, input int lines, input int ppl, input int last_ppl);
    int acc = 0;
    for (int l = 0; l < lines; l++)
      for (int p = 0; p < ((l == lines - 1) ? last_ppl : ppl); p++)
        acc += (s << 12) + (l << 8) + p;
    return acc;
  endfunction

  task automatic chk_frame(input string tag, input int idx, input int s, input int pix, input int sum);
    chk({tag, "_src"}, fr_src[idx], s);
    chk({tag, "_pix"}, fr_pix[idx], pix);
    chk({tag, "_mixed"}, fr_mix[idx], 0);
    chk({tag, "_sum"}, fr_sum[idx], sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, fc0, nfall0, en0, ep0;

  initial begin
    // Reset values.
    repeat (3) @(negedge cam_pclk);
    chk("rst_vsync", img_vsync, 1);
    chk("rst_en", img_data_en, 0);
    chk("rst_data", img_data, 0);
    chk("rst_cur_src", cur_src, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_timeout", src_timeout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge cam_pclk);
    transfer_flag = 1'b1;
    repeat (3) @(negedge cam_pclk);

    // 1: mode 00, one good src0 frame.
    send_frame(0, 3, 4, 4);
    chk("t1_latency", img_fall_cyc - drv_fall_cyc[0], 2);
    chk("t1_frames", nfr, 1);
    chk_frame("t1", 0, 0, 12, exp_sum(0, 3, 4, 4));
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_no_err", err_pulses, 0);

    // 2: alternate mode, both sources streaming.
    cfg_mode = 2'b10;
    base = nfr;
    fork
      begin repeat (3) send_frame(0, 3, 4, 4); end
      begin repeat (3) send_frame(1, 3, 4, 4); end
    join
    chk("t2_frames", nfr - base, 3);
    chk_frame("t2_f0", base, 0, 12, exp_sum(0, 3, 4, 4));
    chk_frame("t2_f1", base + 1, 1, 12, exp_sum(1, 3, 4, 4));
    chk_frame("t2_f2", base + 2, 0, 12, exp_sum(0, 3, 4, 4));
    chk("t2_frame_cnt", frame_cnt, 4);
    chk("t2_cur_src", cur_src, 1);

    // 3: src1 silent -> skip after 1 EOF cycle plus 100 waiting cycles, then src0 passes.
    for (int i = 0; i < 300; i++) begin
      @(negedge cam_pclk);
      if (to_pulses > 0) break;
    end
    chk("t3_to_pulses", to_pulses, 1);
    chk("t3_to_delay", to_cyc - rise_cyc, 101);
    @(negedge cam_pclk);
    chk("t3_to_width", to_hi, 1);
    chk("t3_cur_src", cur_src, 0);
    base = nfr;
    send_frame(0, 3, 4, 4);
    chk_frame("t3_next", base, 0, 12, exp_sum(0, 3, 4, 4));
    // Back to fixed src0 via IDLE.
    transfer_flag = 1'b0;
    cfg_mode = 2'b00;
    repeat (2) @(negedge cam_pclk);
    transfer_flag = 1'b1;
    repeat (3) @(negedge cam_pclk);
    chk("t3_idle_cur_src", cur_src, 0);

    // 4: short line, then too few lines.
    fc0 = frame_cnt;
    send_frame(0, 3, 4, 3);
    chk("t4_short_line_err", err_pulses, 1);
    chk("t4_err_width", err_hi, 1);
    chk("t4_cnt_on_err", frame_cnt - fc0, 1);
    send_frame(0, 2, 4, 4);
    chk("t4_two_line_err", err_pulses, 2);
    chk("t4_cnt_on_err2", frame_cnt - fc0, 2);

    // 5: disable in line 2, re-enable mid-frame.
    fc0 = frame_cnt;
    base = nfall;
    fork
      send_frame(0, 3, 4, 4);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge cam_pclk);
          #1;
          if (nfall > base && cur_pix >= 5) break;
        end
        chk("t5_reached_line2", int'(cur_pix >= 5), 1);
        transfer_flag = 1'b0;
        @(negedge cam_pclk);
        chk("t5_idle_vsync", img_vsync, 1);
        chk("t5_idle_en", img_data_en, 0);
        repeat (2) @(negedge cam_pclk);
        transfer_flag = 1'b1;
        nfall0 = nfall;
        en0 = en_total;
      end
    join
    repeat (4) @(negedge cam_pclk);
    chk("t5_no_partial_sof", nfall - nfall0, 0);
    chk("t5_no_partial_en", en_total - en0, 0);
    chk("t5_frame_cnt_hold", frame_cnt - fc0, 0);
    base = nfr;
    send_frame(0, 3, 4, 4);
    chk_frame("t5_fresh", base, 0, 12, exp_sum(0, 3, 4, 4));
    chk("t5_frame_cnt", frame_cnt - fc0, 1);

    // 6: cfg_mode 00 -> 01 mid-frame.
    ep0 = err_pulses;
    base = nfr;
    fork
      send_frame(0, 3, 4, 4);
      begin repeat (10) @(negedge cam_pclk); cfg_mode = 2'b01; end
    join
    chk_frame("t6_cur", base, 0, 12, exp_sum(0, 3, 4, 4));
    chk("t6_cur_src", cur_src, 1);
    fork
      send_frame(0, 3, 4, 4);
      send_frame(1, 3, 4, 4);
    join
    chk_frame("t6_next", base + 1, 1, 12, exp_sum(1, 3, 4, 4));
    chk("t6_no_err", err_pulses - ep0, 0);

    // Fixed mode with a silent source: the timeout saturates without a skip.
    repeat (250) @(negedge cam_pclk);
    chk("sat_no_timeout", to_pulses, 1);
    chk("sat_cur_src", cur_src, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
